button_run_ctrl: RTL



---
 rtl/button_run_ctrl_pkg.sv | 17 +
 rtl/button_run_ctrl_run_watchdog.sv | 30 +++
 rtl/button_run_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/button_run_ctrl_pkg.sv
// Shared definitions for the button-driven run controller: state encodings and width helper.
package button_run_ctrl_pkg;

  typedef logic [2:0] stateT;

  localparam stateT IDLE      = 3'd0;
  localparam stateT ISSUE     = 3'd1;
  localparam stateT START     = 3'd2;
  localparam stateT WAIT_DONE = 3'd3;
  localparam stateT ERR       = 3'd4;

  // clog2 that never collapses to a zero-width vector
  function automatic int widthOf(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_run_ctrl_run_watchdog.sv
// Cycle counter that flags a core that stays in WAIT_DONE for TIMEOUT cycles without completing.
module run_watchdog
  import button_run_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1000000
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iClear,
  input  logic iCount,
  output logic oExpire
);

  localparam int CW = widthOf(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge iClk) begin
    if (iRst || iClear) begin
      count <= '0;
    end else if (iCount) begin
      count <= count + CW'(1);
    end
  end

  // Fires on the cycle the count would reach TIMEOUT, so the FSM lands in ERR exactly TIMEOUT cycles after entry
  assign oExpire = (TIMEOUT != 0) && iCount && (count == LAST);

endmodule

// File: rtl/button_run_ctrl.sv
// Turns synchronized start/mode button pulses into a one-deep-queued start handshake for the CNN core.
//  state     | meaning
//  IDLE      | no run; mode press cycles mode, start press launches
//  ISSUE     | waiting for core ready
//  START     | one-cycle start strobe to core
//  WAIT_DONE | run in flight, watchdog counting
//  ERR       | core never finished; start press acknowledges
module button_run_ctrl
  import button_run_ctrl_pkg::*;
#(
  parameter int MODE_NUM = 4,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iStartBtn,
  input  logic                          iModeBtn,
  input  logic                          iCoreReady,
  input  logic                          iCoreDone,
  output logic                          oCoreStart,
  output logic [widthOf(MODE_NUM)-1:0]  oMode,
  output logic                          oBusy,
  output logic                          oPending,
  output logic                          oErr,
  output logic [CNT_W-1:0]              oRunCount
);

  localparam int MODE_W = widthOf(MODE_NUM);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);

  stateT state, stateNext;
  logic  inWait, doneHit, wdExpire;

  assign inWait  = (state == WAIT_DONE);
  assign doneHit = inWait && iCoreDone;

  run_watchdog #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .iClk    (iClk),
    .iRst    (iRst),
    .iClear  (!inWait),
    .iCount  (inWait && !iCoreDone),
    .oExpire (wdExpire)
  );

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (iStartBtn) stateNext = ISSUE;
      ISSUE:     if (iCoreReady) stateNext = START;
      START:     stateNext = WAIT_DONE;
      WAIT_DONE: begin
        // done beats a simultaneous watchdog expiry
        if (iCoreDone)     stateNext = (oPending || iStartBtn) ? ISSUE : IDLE;
        else if (wdExpire) stateNext = ERR;
      end
      ERR:       if (iStartBtn) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_comb begin
    oCoreStart = 1'b0;
    oBusy      = 1'b0;
    oErr       = 1'b0;
    case (state)
      ISSUE:     oBusy = 1'b1;
      START:     begin oBusy = 1'b1; oCoreStart = 1'b1; end
      WAIT_DONE: oBusy = 1'b1;
      ERR:       oErr = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oMode     <= '0;
      oPending  <= 1'b0;
      oRunCount <= '0;
    end else begin
      if (state == IDLE && iModeBtn) begin
        oMode <= (oMode == MODE_LAST) ? '0 : oMode + MODE_W'(1);
      end
      if (doneHit) begin
        oRunCount <= oRunCount + CNT_W'(1);
      end
      // a done consumes the queued press (or a same-cycle press); expiry drops it
      if (doneHit || (inWait && wdExpire)) begin
        oPending <= 1'b0;
      end else if (iStartBtn && oBusy) begin
        oPending <= 1'b1;
      end
    end
  end

endmodule
